// File: rtl/data_pack.sv
// Deserializer: packs LSB-first DATA_WIDTH-bit values into WORD_WIDTH-bit words,
// with sop/eop framing and a single registered output slot under backpressure.
module data_pack #(
    parameter int WORD_WIDTH = 32,
    parameter int DATA_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  sop_in,
    input  logic                  eop_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  sop_out,
    output logic                  eop_out
);

    localparam int ACC_W  = WORD_WIDTH + DATA_WIDTH - 1;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam logic [FILL_W-1:0] WORD_N = FILL_W'(WORD_WIDTH);
    localparam logic [FILL_W-1:0] DATA_N = FILL_W'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

    state_t                state, state_nx;
    logic [ACC_W-1:0]      acc, acc_nx, acc_wr;
    logic [FILL_W-1:0]     fill, fill_nx, base, n;
    logic                  first_pend, first_pend_nx, first_w;
    logic                  slot_free, accept, emit;
    logic [WORD_WIDTH-1:0] word_nx;
    logic                  sop_nx, eop_nx;

    function automatic logic [ACC_W-1:0] insert_val(input logic [ACC_W-1:0] a,
                                                    input logic [FILL_W-1:0] pos,
                                                    input logic [DATA_WIDTH-1:0] v);
        logic [ACC_W-1:0] m;
        m = {{(ACC_W-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}} << pos;
        insert_val = (a & ~m) | ({{(ACC_W-DATA_WIDTH){1'b0}}, v} << pos);
    endfunction

    function automatic logic [WORD_WIDTH-1:0] keep_low(input logic [WORD_WIDTH-1:0] w,
                                                       input logic [FILL_W-1:0] cnt);
        keep_low = w & ~({WORD_WIDTH{1'b1}} << cnt);
    endfunction

    assign slot_free = !valid_out || ready_in;
    assign ready_out = (state != FLUSH) && slot_free;
    assign accept    = valid_in && ready_out;

    // A sop always restarts at bit 0, dropping any residual of an aborted packet.
    assign base   = sop_in ? '0 : fill;
    assign acc_wr = insert_val(sop_in ? '0 : acc, base, data_in);
    assign n      = base + DATA_N;

    always_comb begin
        state_nx      = state;
        acc_nx        = acc;
        fill_nx       = fill;
        first_pend_nx = first_pend;
        first_w       = sop_in || first_pend;
        emit          = 1'b0;
        word_nx       = '0;
        sop_nx        = 1'b0;
        eop_nx        = 1'b0;
        case (state)
            IDLE, PACK: begin
                if (accept && (state == PACK || sop_in)) begin
                    if (eop_in && n <= WORD_N) begin
                        emit          = 1'b1;
                        word_nx       = keep_low(acc_wr[WORD_WIDTH-1:0], n);
                        sop_nx        = first_w;
                        eop_nx        = 1'b1;
                        acc_nx        = '0;
                        fill_nx       = '0;
                        first_pend_nx = 1'b0;
                        state_nx      = IDLE;
                    end else if (n >= WORD_N) begin
                        emit          = 1'b1;
                        word_nx       = acc_wr[WORD_WIDTH-1:0];
                        sop_nx        = first_w;
                        acc_nx        = acc_wr >> WORD_WIDTH;
                        fill_nx       = n - WORD_N;
                        first_pend_nx = 1'b0;
                        state_nx      = eop_in ? FLUSH : PACK;
                    end else begin
                        acc_nx        = acc_wr;
                        fill_nx       = n;
                        first_pend_nx = first_w;
                        state_nx      = PACK;
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    emit     = 1'b1;
                    word_nx  = keep_low(acc[WORD_WIDTH-1:0], fill);
                    eop_nx   = 1'b1;
                    acc_nx   = '0;
                    fill_nx  = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            acc        <= '0;
            fill       <= '0;
            first_pend <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            sop_out    <= 1'b0;
            eop_out    <= 1'b0;
        end else begin
            state      <= state_nx;
            acc        <= acc_nx;
            fill       <= fill_nx;
            first_pend <= first_pend_nx;
            if (emit) begin
                valid_out <= 1'b1;
                data_out  <= word_nx;
                sop_out   <= sop_nx;
                eop_out   <= eop_nx;
            end else if (ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_pack.sv
// Directed bench for data_pack: packing, framing, flush, backpressure and reset.
module tb_data_pack;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [6:0]  data_in;
    logic        sop_in;
    logic        eop_in;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] data_out;
    logic        sop_out;
    logic        eop_out;

    data_pack #(.WORD_WIDTH(32), .DATA_WIDTH(7)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .ready_out(ready_out), .data_in(data_in),
        .sop_in(sop_in), .eop_in(eop_in),
        .valid_out(valid_out), .ready_in(ready_in), .data_out(data_out),
        .sop_out(sop_out), .eop_out(eop_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] wq[$];
    logic        sq[$];
    logic        eq[$];
    int          rdy_low = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (valid_out && ready_in) begin
                wq.push_back(data_out);
                sq.push_back(sop_out);
                eq.push_back(eop_out);
            end
            if (!ready_out) rdy_low = rdy_low + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [6:0] v, input logic s, input logic e);
        int waits;
        valid_in = 1'b1;
        data_in  = v;
        sop_in   = s;
        eop_in   = e;
        waits    = 0;
        @(negedge clk);
        while (!ready_out && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) check("send_timeout", 32'(waits), 32'(0));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    logic [6:0] pkt1 [10] = '{7'h5A, 7'h00, 7'h33, 7'h00, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h7D, 7'h40};

    initial begin
        int base;
        int rbase;
        int hold_err;
        int rdy_err;
        rst      = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
        ready_in = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_out), 32'(0));
        check("rst_data", data_out, 32'h0);
        check("rst_sop", 32'(sop_out), 32'(0));
        check("rst_eop", 32'(eop_out), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        check("rst_ready", 32'(ready_out), 32'(1));

        // ten-value packet, word presented the cycle after the completing accept
        for (int i = 0; i < 10; i++) begin
            send(pkt1[i], i == 0, 1'b0);
            if (i == 4) begin
                check("p1_w0_valid", 32'(valid_out), 32'(1));
                check("p1_w0_data", data_out, 32'hF00CC05A);
                check("p1_w0_sop", 32'(sop_out), 32'(1));
                check("p1_w0_eop", 32'(eop_out), 32'(0));
            end
        end
        check("p1_w1_valid", 32'(valid_out), 32'(1));
        check("p1_w1_data", data_out, 32'h7D000007);
        check("p1_w1_sop", 32'(sop_out), 32'(0));

        // single-value packet also aborts the open residual
        send(7'h55, 1'b1, 1'b1);
        check("single_data", data_out, 32'h00000055);
        check("single_sop", 32'(sop_out), 32'(1));
        check("single_eop", 32'(eop_out), 32'(1));
        idle(2);
        check("single_drained", 32'(valid_out), 32'(0));

        // 32-value packet: exactly seven words, no flush
        base  = wq.size();
        rbase = rdy_low;
        for (int i = 0; i < 32; i++) send(7'(i + 1), i == 0, i == 31);
        idle(3);
        check("p32_count", 32'(wq.size() - base), 32'd7);
        check("p32_w0", wq[base], 32'h5080C101);
        check("p32_w0_sop", 32'(sq[base]), 32'(1));
        check("p32_w6", wq[base+6], 32'h407CF1D3);
        check("p32_w6_eop", 32'(eq[base+6]), 32'(1));
        check("p32_w5_eop", 32'(eq[base+5]), 32'(0));
        check("p32_rdy_low", 32'(rdy_low - rbase), 32'(0));

        // five-value packet ending in a flush word
        base  = wq.size();
        rbase = rdy_low;
        send(7'h01, 1'b1, 1'b0);
        send(7'h02, 1'b0, 1'b0);
        send(7'h03, 1'b0, 1'b0);
        send(7'h04, 1'b0, 1'b0);
        send(7'h7F, 1'b0, 1'b1);
        idle(3);
        check("p5_count", 32'(wq.size() - base), 32'd2);
        check("p5_w0", wq[base], 32'hF080C101);
        check("p5_w0_flags", {30'b0, sq[base], eq[base]}, 32'b10);
        check("p5_flush", wq[base+1], 32'h00000007);
        check("p5_flush_flags", {30'b0, sq[base+1], eq[base+1]}, 32'b01);
        check("p5_rdy_low", 32'(rdy_low - rbase), 32'(1));

        // values outside a packet are discarded
        base = wq.size();
        send(7'h11, 1'b0, 1'b0);
        send(7'h22, 1'b0, 1'b1);
        send(7'h33, 1'b0, 1'b0);
        send(7'h05, 1'b1, 1'b0);
        send(7'h06, 1'b0, 1'b1);
        idle(3);
        check("disc_count", 32'(wq.size() - base), 32'd1);
        check("disc_word", wq[base], 32'h00000305);
        check("disc_flags", {30'b0, sq[base], eq[base]}, 32'b11);

        // backpressure: output held, input stalled, nothing lost
        base     = wq.size();
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) send(7'(i + 1), i == 0, 1'b0);
        valid_in = 1'b1;
        data_in  = 7'h06;
        eop_in   = 1'b1;
        hold_err = 0;
        rdy_err  = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid_out !== 1'b1 || data_out !== 32'h5080C101 ||
                sop_out !== 1'b1 || eop_out !== 1'b0) hold_err++;
            if (ready_out !== 1'b0) rdy_err++;
        end
        check("bp_hold", 32'(hold_err), 32'(0));
        check("bp_ready_low", 32'(rdy_err), 32'(0));
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        send(7'h06, 1'b0, 1'b1);
        idle(3);
        check("bp_count", 32'(wq.size() - base), 32'd2);
        check("bp_w0", wq[base], 32'h5080C101);
        check("bp_w1", wq[base+1], 32'h00000030);
        check("bp_w1_eop", 32'(eq[base+1]), 32'(1));

        // reset mid-packet with a word pending
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) send(7'(i + 1), i == 0, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_out), 32'(0));
        check("mid_rst_data", data_out, 32'h0);
        check("mid_rst_sop", 32'(sop_out), 32'(0));
        @(negedge clk);
        rst      = 1'b1;
        ready_in = 1'b1;
        idle(1);
        base = wq.size();
        send(7'h12, 1'b1, 1'b0);
        send(7'h34, 1'b0, 1'b1);
        idle(3);
        check("post_rst_count", 32'(wq.size() - base), 32'd1);
        check("post_rst_word", wq[base], 32'h00001A12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_pack.md
Name: data_pack

Overview:
- Deserializer for the 7-bit value stream: packs LSB-first DATA_WIDTH-bit values into WORD_WIDTH-bit words.
- Performs the inverse of the 32-to-7 unpack path. It is used to reassemble packets on the return path or in loopback test fixtures.
- Input side: valid/ready handshake with sop/eop flags.
- Output side: registered word with valid/ready backpressure.

Parameters:
WORD_WIDTH, 32, output word width
DATA_WIDTH, 7, input value width (must be < WORD_WIDTH)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low
valid_in  input  1  data_in valid
ready_out  output  1  block can accept a value; transfer when valid_in && ready_out
data_in  input  DATA_WIDTH  input value
sop_in  input  1  first value of packet
eop_in  input  1  last value of packet
valid_out  output  1  data_out holds a word
ready_in  input  1  downstream accepts word; transfer when valid_out && ready_in
data_out  output  WORD_WIDTH  packed word
sop_out  output  1  first word of packet, qualified by valid_out
eop_out  output  1  last word of packet, qualified by valid_out

Behaviour:
- Reset (rst low, asynchronous):
  - valid_out=0, data_out=0, sop_out=0, eop_out=0.
  - Accumulator and fill count are cleared; state=IDLE.
  - ready_out=1 after reset releases.
- Storage:
  - Accumulator acc is WORD_WIDTH+DATA_WIDTH-1 bits (38).
  - fill is 6 bits, range 0..WORD_WIDTH-1 between accepts.
  - Each accepted value is written at acc[fill +: DATA_WIDTH].
- Output slot:
  - A single registered word; it is "free" when !valid_out || ready_in.
  - ready_out = (state != FLUSH) && slot free. It is combinational from ready_in and registered state.
- States:
  - IDLE (no packet in progress), PACK (packet in progress), FLUSH (residual word pending after eop).
- IDLE:
  - Accepted value with sop_in=0 is consumed and discarded (still handshaken).
  - Accepted value with sop_in=1: write at fill=0, mark first-word-pending, go to PACK. If eop_in is also set, handle as eop (below).
- PACK, accepted value, let n = fill + DATA_WIDTH:
  - n < WORD_WIDTH, eop_in=0: fill = n, no output.
  - n >= WORD_WIDTH: load data_out = acc[WORD_WIDTH-1:0] including the new value, and set valid_out next cycle.
    - sop_out = first-word-pending, which is then cleared.
    - acc is shifted right by WORD_WIDTH; fill = n - WORD_WIDTH.
  - eop_in=1 and n <= WORD_WIDTH: emit the word immediately with bits above n zeroed and eop_out=1. Clear acc and fill; go to IDLE.
  - eop_in=1 and n > WORD_WIDTH: emit the full word (eop_out=0) and go to FLUSH.
- FLUSH:
  - ready_out=0.
  - When the slot is free, emit acc[WORD_WIDTH-1:0] with bits >= fill zeroed, eop_out=1, sop_out=0.
  - Clear acc and fill; go to IDLE.
  - Costs at most one dead input cycle between packets.
- sop_in on an accepted value while in PACK:
  - Residual bits are discarded.
  - The new packet starts at fill=0 with first-word-pending set.
  - No eop is generated for the aborted packet.
- Latency and throughput:
  - A word is presented the cycle after the accept that completes it.
  - The block sustains 1 value/cycle with ready_in held high.
- Output hold: data_out, sop_out and eop_out stay stable while valid_out && !ready_in.
- Single-value packet (sop_in && eop_in): one word, value in [DATA_WIDTH-1:0], upper bits 0, sop_out=eop_out=1.
- rst asserted mid-packet or mid-FLUSH: pending word and residual are lost; nothing is emitted.

Test Plan:
- Packet values 0x5A,0x00,0x33,0x00,0x7F,0x00,0x00,0x00,0x7D,0x40 (sop on first), ready_in=1 -> word0=0xF00CC05A (sop_out=1) one cycle after the 5th accept; word1=0x7D000007 one cycle after the 10th accept.
- Single value 0x55 with sop_in=eop_in=1 -> one word 0x00000055, sop_out=1, eop_out=1; state returns to IDLE.
- 32-value packet (224 bits), eop on value 32 -> exactly 7 words; eop_out only on word 7; FLUSH never entered; ready_out never deasserts with ready_in=1.
- 5-value packet with eop on value 5 -> word 1 (sop_out=1, eop_out=0), then FLUSH word = 3 residual bits, upper 29 bits zero, eop_out=1. ready_out=0 for exactly 1 cycle.
- Values without sop after an eop, then a sop packet -> leading values discarded; first output word contains only post-sop values.
- ready_in held low 10 cycles with valid_out=1 -> data_out, sop_out, eop_out stable; ready_out=0 throughout; no value lost after release.
- rst pulsed low mid-packet -> outputs 0 immediately; next sop packet packs from bit 0.
